rf_writeback_queue: RTL and testbench
=====================================

# rf_writeback_queue

Buffered write-back initiator for the 16-bit single-cycle RISC core's 16×16-bit register file. It accepts destination-register writes from the execute/memory stage over a valid/ready handshake and holds them in a small in-order FIFO. It retires one write per cycle into the register file's `Rd`/`RW`/`wr` write port. It also forwards pending data onto the two read paths (`Rs`/`Rt`), so consumers always see the newest architectural value.

## Interface
- `DEPTH`, default 4 — queue entries; power of two, ≥2.
- `clk`  in  1  — core clock; all state updates on rising edge.
- `rst`  in  1  — reset, asynchronous, active-high.
- `in_valid`  in  1  — write request present.
- `in_rd`  in  4  — destination register index.
- `in_data`  in  16  — write data.
- `in_ready`  out  1  — queue can accept this cycle.
- `rf_hold`  in  1  — freeze draining; the queue still accepts while not full.
- `rf_rd`  out  4  — to register file `Rd`.
- `rf_rw`  out  16  — to register file `RW`.
- `rf_wr`  out  1  — to register file `wr`.
- `rs`, `rt`  in  4 each  — read indices, also driven to register file `Rs`/`Rt`.
- `rf_rout1`, `rf_rout2`  in  16 each  — raw register file read data.
- `rout1`, `rout2`  out  16 each  — forwarded read data.
- `count`  out  $clog2(DEPTH)+1  — occupied entries.
- `empty`  out  1  — `count == 0`.

## Operation
- **Storage:** circular FIFO of `{rd[3:0], data[15:0]}` with `wr_ptr` and `rd_ptr` of width $clog2(DEPTH) that wrap modulo DEPTH, plus a `count` register.
- **Enqueue:** occurs when `in_valid && in_ready`.
  - `in_ready = (count < DEPTH)`.
  - `in_ready` depends on registered state only. There is no same-cycle pass-through, even if a drain occurs in that cycle.
- **Drain:** occurs when `!empty && !rf_hold`.
  - `rf_wr = !empty && !rf_hold`.
  - `rf_rd`/`rf_rw` = head entry. When `rf_wr = 0` they hold the head entry, or 0 when empty.
  - The register file always accepts, so the drain completes at the edge.
- **Simultaneous enqueue and drain:** `count` is unchanged and both pointers advance.
  - When full, only a drain can occur in that cycle, because `in_ready` = 0.
- **Forwarding:**
  - `rout1` = data of the youngest valid entry with `rd == rs`, searching from `wr_ptr-1` back to `rd_ptr`. If no entry matches, `rout1 = rf_rout1`.
  - `rout2` uses the same rule with `rt` and `rf_rout2`.
  - The entry draining this cycle still participates, because the register file updates only at the edge.
  - An incoming `in_*` request is not forwarded in the cycle it is presented.
- **Duplicate destinations:** multiple entries with the same `rd` are legal. They drain in order; the last one wins in the register file, and the youngest wins in forwarding.
- **Register 0:** no special treatment; it is writable like any other register.
- **Reset:**
  - Pointers and `count` are cleared, and all pending writes are discarded.
  - Outputs after reset: `rf_wr`=0, `rf_rd`=0, `rf_rw`=0, `in_ready`=1, `empty`=1, `count`=0.
  - `rout1`/`rout2` pass `rf_rout1`/`rf_rout2` through.
  - Assertion mid-drain aborts the in-flight write. Entry storage need not be cleared, because valid status derives from the pointers.

## Timing
- Enqueue accepted at edge N into an empty queue: `rf_wr`=1 during cycle N→N+1, and the register file is written at edge N+1.
- Minimum enqueue-to-architectural latency is 1 cycle. Forwarding is visible from the cycle after edge N.
- Throughput: 1 write per cycle sustained with `DEPTH` ≥ 2.
- `rf_wr`, `rf_rd`, `rf_rw`, `in_ready`, `count` and `empty` are combinational from registers only.
- `rout1`/`rout2` are combinational from `rs`/`rt`, `rf_rout*` and registers. There is no path from `in_*`.
- `rf_hold` gates `rf_wr` combinationally in the same cycle.

## Structure
- Shared package `risc16_pkg`:
  - `REG_ADDR_W`=4, `DATA_W`=16, `NUM_REGS`=16.
  - typedef `wb_entry_t {logic [3:0] rd; logic [15:0] data;}`.
  - These are reused by the register file and decode.
- Sub-module `wbq_fwd_match`: parameterised DEPTH-way youngest-first priority matcher.
  - Inputs: entry array, `rd_ptr`, `count`, query index.
  - Outputs: `hit`, `data`.
  - Instantiated twice, once for `rs` and once for `rt`.

## Test plan
- **Reset:** assert `rst` mid-stream with 3 entries queued. Required: `rf_wr`=0 and `count`=0 immediately (asynchronously), and no write occurs after release.
- **Single write:** enqueue {rd=5, data=0xBEEF} into an empty queue. Required: `rf_wr`=1, `rf_rd`=5, `rf_rw`=0xBEEF the next cycle. `rs`=5 gives `rout1`=0xBEEF while `rf_rout1`=0x0000.
- **Hold and full:** with `rf_hold`=1, enqueue 4 writes. Required: `in_ready`=0 and `count`=4. A 5th `in_valid` is not accepted. Release hold: 4 consecutive `rf_wr` pulses in FIFO order, and `in_ready` returns to 1 after the first.
- **Youngest-wins forwarding:** enqueue rd=3 with 0x1111, then rd=3 with 0x2222, under hold. Required: `rs`=`rt`=3 gives `rout1`=`rout2`=0x2222. After draining both, `rout1` = `rf_rout1`.
- **Steady state and wrap-around:** back-to-back enqueue every cycle for 20 cycles with no hold. Required: `count` stays ≤1 and the writes appear in order with 1-cycle latency. Pointers wrap past DEPTH without loss or duplication.

Source files
------------

// File: rtl/risc16_pkg.sv
// Shared types and sizes for the 16-bit RISC core: register file geometry and
// the write-back entry format used by the write-back queue, register file and decode.
// No logic; constants and typedefs only.
package risc16_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 16;
  localparam int NUM_REGS   = 16;

  // One pending register-file write: destination index plus data.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wbq_fwd_match.sv
// Purpose: youngest-first match of a register index against the occupied queue entries.
// Latency: purely combinational.
// Backpressure: none; only observes queue state.
//
// Ports:
//   entries  - full entry storage array (indexed by physical slot)
//   rd_ptr   - slot of the oldest occupied entry
//   count    - number of occupied entries
//   query    - register index being read
//   hit      - some occupied entry targets query
//   data     - data of the youngest such entry (0 when no hit)
module wbq_fwd_match
  import risc16_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  wb_entry_t             entries [DEPTH],
  input  logic [PW-1:0]         rd_ptr,
  input  logic [CW-1:0]         count,
  input  logic [REG_ADDR_W-1:0] query,
  output logic                  hit,
  output logic [DATA_W-1:0]     data
);

  logic [PW-1:0] slot;

  // Walk entries oldest to youngest; a later match overwrites an earlier one,
  // so the youngest match is what remains at the end of the loop.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_ptr + PW'(i);
      if (CW'(i) < count) begin
        if (entries[slot].rd == query) begin
          hit  = 1'b1;
          data = entries[slot].data;
        end
      end
    end
  end

endmodule

// File: rtl/rf_writeback_queue.sv
// Purpose: in-order buffered write-back into the register file with read forwarding.
// Latency: accepted write drains one cycle later (next edge) unless rf_hold is set.
// Backpressure: in_ready drops when all DEPTH entries are occupied; no same-cycle pass-through.
//
// Ports:
//   clk, rst                     - core clock, async active-high reset
//   in_valid/in_ready/in_rd/in_data - write request handshake from execute/memory
//   rf_hold                      - freeze draining (acceptance continues while not full)
//   rf_rd/rf_rw/rf_wr            - register file write port (Rd/RW/wr)
//   rs/rt                        - read indices (also feed register file Rs/Rt)
//   rf_rout1/rf_rout2            - raw register file read data
//   rout1/rout2                  - read data with pending writes forwarded
//   count/empty                  - occupancy status
module rf_writeback_queue
  import risc16_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  input  logic                  rf_hold,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0]     rf_rw,
  output logic                  rf_wr,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [DATA_W-1:0]     rf_rout1,
  input  logic [DATA_W-1:0]     rf_rout2,
  output logic [DATA_W-1:0]     rout1,
  output logic [DATA_W-1:0]     rout2,
  output logic [CW-1:0]         count,
  output logic                  empty
);

  wb_entry_t     mem [DEPTH];
  wb_entry_t     head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          enq;
  logic          drn;

  logic                fwd1_hit;
  logic                fwd2_hit;
  logic [DATA_W-1:0]   fwd1_data;
  logic [DATA_W-1:0]   fwd2_data;

  // Status and handshake: all from registered state only.
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign in_ready = (cnt < CW'(DEPTH));
  assign enq      = in_valid && in_ready;
  assign drn      = !empty && !rf_hold;

  // Write port: head entry is shown whenever the queue is non-empty, even
  // while held, so the register file sees stable values before wr rises.
  assign head  = mem[rd_ptr];
  assign rf_wr = drn;
  assign rf_rd = empty ? '0 : head.rd;
  assign rf_rw = empty ? '0 : head.data;

  // Entry storage carries no reset: occupancy comes from the pointers/count.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= '{rd: in_rd, data: in_data};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (drn) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      unique case ({enq, drn})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Forwarding includes the entry draining this cycle: the register file
  // only takes the new value at the coming edge.
  wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd_rs (
    .entries (mem),
    .rd_ptr  (rd_ptr),
    .count   (cnt),
    .query   (rs),
    .hit     (fwd1_hit),
    .data    (fwd1_data)
  );

  wbq_fwd_match #(.DEPTH(DEPTH)) u_fwd_rt (
    .entries (mem),
    .rd_ptr  (rd_ptr),
    .count   (cnt),
    .query   (rt),
    .hit     (fwd2_hit),
    .data    (fwd2_data)
  );

  assign rout1 = fwd1_hit ? fwd1_data : rf_rout1;
  assign rout2 = fwd2_hit ? fwd2_data : rf_rout2;

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Purpose: self-checking bench for rf_writeback_queue against a queue-based model.
// Latency: model retires the oldest write at each edge where a drain is allowed.
// Backpressure: model refuses writes once DEPTH writes are pending.
module tb_rf_writeback_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [3:0]    in_rd;
  logic [15:0]   in_data;
  logic          in_ready;
  logic          rf_hold;
  logic [3:0]    rf_rd;
  logic [15:0]   rf_rw;
  logic          rf_wr;
  logic [3:0]    rs;
  logic [3:0]    rt;
  logic [15:0]   rf_rout1;
  logic [15:0]   rf_rout2;
  logic [15:0]   rout1;
  logic [15:0]   rout2;
  logic [CW-1:0] count;
  logic          empty;

  int tests_run    = 0;
  int tests_failed = 0;

  // Register file driven by the DUT write port.
  logic [15:0] rfile [16];
  // Architectural model: pending writes in order, plus retired register values.
  logic [3:0]  mq_rd  [$];
  logic [15:0] mq_dat [$];
  logic [15:0] mreg   [16];

  always #5 clk = ~clk;

  rf_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_rd    (in_rd),
    .in_data  (in_data),
    .in_ready (in_ready),
    .rf_hold  (rf_hold),
    .rf_rd    (rf_rd),
    .rf_rw    (rf_rw),
    .rf_wr    (rf_wr),
    .rs       (rs),
    .rt       (rt),
    .rf_rout1 (rf_rout1),
    .rf_rout2 (rf_rout2),
    .rout1    (rout1),
    .rout2    (rout2),
    .count    (count),
    .empty    (empty)
  );

  assign rf_rout1 = rfile[rs];
  assign rf_rout2 = rfile[rt];

  always @(posedge clk) begin
    if (rf_wr) rfile[rf_rd] = rf_rw;
  end

  // Newest architectural value of a register: youngest pending write, else retired value.
  function automatic logic [15:0] exp_fwd(input logic [3:0] idx);
    for (int i = mq_rd.size() - 1; i >= 0; i--) begin
      if (mq_rd[i] == idx) return mq_dat[i];
    end
    return mreg[idx];
  endfunction

  function automatic logic [3:0] exp_rd();
    return (mq_rd.size() > 0) ? mq_rd[0] : 4'd0;
  endfunction

  function automatic logic [15:0] exp_rw();
    return (mq_dat.size() > 0) ? mq_dat[0] : 16'd0;
  endfunction

  function automatic logic exp_wr();
    return (mq_rd.size() > 0) && !rf_hold;
  endfunction

  task automatic drive(input logic v, input logic [3:0] d_rd, input logic [15:0] d_dat,
                       input logic h, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    in_valid = v;
    in_rd    = d_rd;
    in_data  = d_dat;
    rf_hold  = h;
    rs       = a;
    rt       = b;
    #1;
  endtask

  // Advance one edge and update the model from the inputs presented.
  task automatic tick();
    logic acc;
    logic drn;
    acc = in_valid && (mq_rd.size() < DEPTH);
    drn = (mq_rd.size() > 0) && !rf_hold;
    @(posedge clk);
    if (drn) begin
      mreg[mq_rd[0]] = mq_dat[0];
      void'(mq_rd.pop_front());
      void'(mq_dat.pop_front());
    end
    if (acc) begin
      mq_rd.push_back(in_rd);
      mq_dat.push_back(in_data);
    end
  endtask

  task automatic test_reset();
    // Reset state.
    tests_run++; if (rf_wr !== 1'b0) begin tests_failed++; $display("FAIL reset_rf_wr got %b want 0", rf_wr); end
    tests_run++; if (count !== '0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", count); end
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty got %b want 1", empty); end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests_run++; if ({rf_rd, rf_rw} !== 20'h0) begin tests_failed++; $display("FAIL reset_rf_port got %h/%h want 0/0", rf_rd, rf_rw); end
    tests_run++; if (rout1 !== rf_rout1) begin tests_failed++; $display("FAIL reset_rout1 got %h want %h", rout1, rf_rout1); end
    @(negedge clk); rst = 1'b0;

    // Three queued writes under hold, then reset in the middle of a drain.
    drive(1, 4'd7, 16'h7777, 1, 0, 0); tick();
    drive(1, 4'd8, 16'h8888, 1, 0, 0); tick();
    drive(1, 4'd9, 16'h9999, 1, 0, 0); tick();
    drive(0, 4'd0, 16'h0, 0, 4'd7, 4'd9);
    tests_run++; if (rf_wr !== 1'b1) begin tests_failed++; $display("FAIL pre_reset_drain got %b want 1", rf_wr); end
    tests_run++; if (count !== CW'(3)) begin tests_failed++; $display("FAIL pre_reset_count got %0d want 3", count); end
    rst = 1'b1;
    #1;
    mq_rd.delete();
    mq_dat.delete();
    tests_run++; if (rf_wr !== 1'b0) begin tests_failed++; $display("FAIL async_reset_rf_wr got %b want 0", rf_wr); end
    tests_run++; if (count !== '0) begin tests_failed++; $display("FAIL async_reset_count got %0d want 0", count); end
    tests_run++; if (rout1 !== exp_fwd(4'd7)) begin tests_failed++; $display("FAIL async_reset_rout1 got %h want %h", rout1, exp_fwd(4'd7)); end
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(0, 4'd0, 16'h0, 0, 4'd8, 4'd9);
      tests_run++; if (rf_wr !== 1'b0) begin tests_failed++; $display("FAIL post_reset_rf_wr cycle %0d got %b want 0", c, rf_wr); end
      tick();
    end
    for (int r = 7; r <= 9; r++) begin
      tests_run++; if (rfile[r] !== mreg[r]) begin tests_failed++; $display("FAIL post_reset_regfile r%0d got %h want %h", r, rfile[r], mreg[r]); end
    end
  endtask

  task automatic test_single_write();
    drive(1, 4'd5, 16'hBEEF, 0, 4'd5, 4'd0); tick();
    drive(0, 4'd0, 16'h0, 0, 4'd5, 4'd0);
    tests_run++; if (rf_wr !== 1'b1) begin tests_failed++; $display("FAIL single_rf_wr got %b want 1", rf_wr); end
    tests_run++; if (rf_rd !== 4'd5) begin tests_failed++; $display("FAIL single_rf_rd got %0d want 5", rf_rd); end
    tests_run++; if (rf_rw !== 16'hBEEF) begin tests_failed++; $display("FAIL single_rf_rw got %h want beef", rf_rw); end
    tests_run++; if (rout1 !== 16'hBEEF) begin tests_failed++; $display("FAIL single_fwd_rout1 got %h want beef (rf_rout1=%h)", rout1, rf_rout1); end
    tick();
    drive(0, 4'd0, 16'h0, 0, 4'd5, 4'd5);
    tests_run++; if (rfile[5] !== 16'hBEEF) begin tests_failed++; $display("FAIL single_regfile got %h want beef", rfile[5]); end
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL single_empty got %b want 1", empty); end
  endtask

  task automatic test_hold_full();
    logic [3:0]  w_rd  [4];
    logic [15:0] w_dat [4];
    for (int i = 0; i < 4; i++) begin
      w_rd[i]  = 4'(i + 10);
      w_dat[i] = 16'($urandom);
      drive(1, w_rd[i], w_dat[i], 1, 0, 0); tick();
    end
    drive(1, 4'd1, 16'hDEAD, 1, 0, 0);
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL full_in_ready got %b want 0", in_ready); end
    tests_run++; if (count !== CW'(4)) begin tests_failed++; $display("FAIL full_count got %0d want 4", count); end
    tests_run++; if (rf_wr !== 1'b0) begin tests_failed++; $display("FAIL hold_rf_wr got %b want 0", rf_wr); end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 4'd0, 16'h0, 0, 4'd1, 4'd1);
      if (i == 0) begin
        tests_run++; if (count !== CW'(4)) begin tests_failed++; $display("FAIL fifth_rejected count got %0d want 4", count); end
      end
      tests_run++; if (rf_wr !== 1'b1) begin tests_failed++; $display("FAIL drain_%0d rf_wr got %b want 1", i, rf_wr); end
      tests_run++; if ({rf_rd, rf_rw} !== {w_rd[i], w_dat[i]}) begin tests_failed++; $display("FAIL drain_%0d order got %0d:%h want %0d:%h", i, rf_rd, rf_rw, w_rd[i], w_dat[i]); end
      tests_run++; if (in_ready !== (i > 0)) begin tests_failed++; $display("FAIL drain_%0d in_ready got %b want %b", i, in_ready, i > 0); end
      tests_run++; if (rout1 !== exp_fwd(4'd1)) begin tests_failed++; $display("FAIL drain_%0d rout1 got %h want %h", i, rout1, exp_fwd(4'd1)); end
      tick();
    end
  endtask

  task automatic test_youngest_wins();
    drive(1, 4'd3, 16'h1111, 1, 4'd3, 4'd3); tick();
    drive(1, 4'd3, 16'h2222, 1, 4'd3, 4'd3); tick();
    drive(0, 4'd0, 16'h0, 1, 4'd3, 4'd3);
    tests_run++; if (rout1 !== 16'h2222) begin tests_failed++; $display("FAIL youngest_rout1 got %h want 2222", rout1); end
    tests_run++; if (rout2 !== 16'h2222) begin tests_failed++; $display("FAIL youngest_rout2 got %h want 2222", rout2); end
    drive(0, 4'd0, 16'h0, 0, 4'd3, 4'd3);
    tests_run++; if (rout1 !== 16'h2222) begin tests_failed++; $display("FAIL draining_rout1 got %h want 2222", rout1); end
    tick();
    drive(0, 4'd0, 16'h0, 0, 4'd3, 4'd3); tick();
    drive(0, 4'd0, 16'h0, 0, 4'd3, 4'd3);
    tests_run++; if (rout1 !== rf_rout1) begin tests_failed++; $display("FAIL drained_rout1 got %h want rf_rout1 %h", rout1, rf_rout1); end
    tests_run++; if (rfile[3] !== 16'h2222) begin tests_failed++; $display("FAIL last_wins_regfile got %h want 2222", rfile[3]); end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 20; c++) begin
      drive(1, 4'($urandom_range(0, 15)), 16'($urandom), 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      tests_run++; if (count > CW'(1)) begin tests_failed++; $display("FAIL b2b_count cycle %0d got %0d want <=1", c, count); end
      tests_run++; if ({rf_wr, rf_rd, rf_rw} !== {exp_wr(), exp_rd(), exp_rw()}) begin
        tests_failed++; $display("FAIL b2b_write cycle %0d got %b:%0d:%h want %b:%0d:%h", c, rf_wr, rf_rd, rf_rw, exp_wr(), exp_rd(), exp_rw());
      end
      tests_run++; if (rout1 !== exp_fwd(rs)) begin tests_failed++; $display("FAIL b2b_rout1 cycle %0d got %h want %h", c, rout1, exp_fwd(rs)); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 99) < 60), 4'($urandom_range(0, 15)), 16'($urandom),
            1'($urandom_range(0, 99) < 35), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      tests_run++;
      if ({rf_wr, rf_rd, rf_rw} !== {exp_wr(), exp_rd(), exp_rw()}) begin
        tests_failed++; $display("FAIL rand_write cycle %0d got %b:%0d:%h want %b:%0d:%h", c, rf_wr, rf_rd, rf_rw, exp_wr(), exp_rd(), exp_rw());
      end
      tests_run++;
      if ({count, empty, in_ready} !== {CW'(mq_rd.size()), mq_rd.size() == 0, mq_rd.size() < DEPTH}) begin
        tests_failed++; $display("FAIL rand_status cycle %0d got cnt=%0d e=%b r=%b want cnt=%0d", c, count, empty, in_ready, mq_rd.size());
      end
      tests_run++;
      if ({rout1, rout2} !== {exp_fwd(rs), exp_fwd(rt)}) begin
        tests_failed++; $display("FAIL rand_fwd cycle %0d got %h/%h want %h/%h", c, rout1, rout2, exp_fwd(rs), exp_fwd(rt));
      end
      tick();
    end
  endtask

  initial begin
    for (int r = 0; r < 16; r++) begin
      rfile[r] = 16'h0;
      mreg[r]  = 16'h0;
    end
    rst      = 1'b1;
    in_valid = 1'b0;
    in_rd    = 4'd0;
    in_data  = 16'h0;
    rf_hold  = 1'b0;
    rs       = 4'd0;
    rt       = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single_write();
    test_hold_full();
    test_youngest_wins();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
